// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-network datapath: top-level sequencer
// state codes, loader stream sizes, the trained layer-one kernels and the
// pixel loader FSM encoding.
package bnn_pkg;

    // Top-level sequencer states seen by the loader.
    localparam logic [2:0] STATE_LOAD = 3'b001;
    localparam logic [2:0] STATE_L1   = 3'b010;

    // Stream sizes in bytes: 784 image bits and 72 kernel bits.
    localparam int PIX_BYTES = 98;
    localparam int WGT_BYTES = 9;

    // Trained 3x3x8 layer-one kernels, bit [r*24 + c*8 + w].
    localparam logic [71:0] DEFAULT_WEIGHTS = 72'hA5_3C_96_0F_E7_5A_C3_69_F0;

    // Pixel loader FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PIX  = 2'd1,
        WGT  = 2'd2,
        DONE = 2'd3
    } loader_state_e;

endpackage

// File: rtl/pixel_loader.sv
// pixel_loader: stages the binarised 28x28 image (and optionally the layer-one
// kernels) from the 8-bit input byte stream into flat vectors for layer one.
// Build option: define PIXEL_LOADER_WEIGHTS_EN to load the 72 kernel bits from
// the stream after the image; otherwise the kernels come from DEFAULT_WEIGHTS.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready is combinational from state and the FSM only, never from in_valid;
// in_valid may be held high while in_ready is low, and such bytes are dropped.
module pixel_loader
    import bnn_pkg::STATE_LOAD;
    import bnn_pkg::DEFAULT_WEIGHTS;
    import bnn_pkg::loader_state_e;
    import bnn_pkg::IDLE;
    import bnn_pkg::PIX;
    import bnn_pkg::WGT;
    import bnn_pkg::DONE;
#(
    parameter int PIX_BYTES = bnn_pkg::PIX_BYTES,
    parameter int WGT_BYTES = bnn_pkg::WGT_BYTES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               state,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [8*PIX_BYTES-1:0]   pixels,
    output logic [71:0]              weights,
    output logic                     load_done,
    output loader_state_e            dbg_fsm_state
);

    // One counter serves both phases, so it is sized for the longer one.
    localparam int CNT_MAX = (PIX_BYTES > WGT_BYTES) ? PIX_BYTES : WGT_BYTES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_BYTES - 1);

    loader_state_e          fsm_q, fsm_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [8*PIX_BYTES-1:0] pix_q, pix_d;
    logic                   active;
    logic                   pix_we;

    assign active = (state == STATE_LOAD);

    // Next-state, byte counter and handshake; everything pauses while the
    // sequencer is outside LOAD because in_ready drops with it.
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        pix_we   = 1'b0;
        in_ready = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (active) begin
                    fsm_d = PIX;
                end
            end
            PIX: begin
                in_ready = active;
                if (active && in_valid) begin
                    pix_we = 1'b1;
                    if (cnt_q == PIX_LAST) begin
                        cnt_d = '0;
`ifdef PIXEL_LOADER_WEIGHTS_EN
                        fsm_d = WGT;
`else
                        fsm_d = DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef PIXEL_LOADER_WEIGHTS_EN
            WGT: begin
                in_ready = active;
                if (active && in_valid) begin
                    if (cnt_q == CNT_W'(WGT_BYTES - 1)) begin
                        fsm_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                fsm_d = DONE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // Pixel byte lanes: the counter decodes to one write enable per byte.
    always_comb begin
        pix_d = pix_q;
        for (int k = 0; k < PIX_BYTES; k++) begin
            if (pix_we && (cnt_q == CNT_W'(k))) begin
                pix_d[8*k +: 8] = in_data;
            end
        end
    end

    // FSM, counter and image register; reset discards any partial image.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            pix_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            pix_q <= pix_d;
        end
    end

`ifdef PIXEL_LOADER_WEIGHTS_EN
    logic [71:0] wgt_q, wgt_d;
    logic        wgt_we;

    assign wgt_we = (fsm_q == WGT) && in_ready && in_valid;

    // Weight byte lanes, decoded from the same counter during WGT.
    always_comb begin
        wgt_d = wgt_q;
        for (int j = 0; j < WGT_BYTES; j++) begin
            if (wgt_we && (cnt_q == CNT_W'(j))) begin
                wgt_d[8*j +: 8] = in_data;
            end
        end
    end

    // Weight register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wgt_q <= '0;
        end else begin
            wgt_q <= wgt_d;
        end
    end

    assign weights = wgt_q;
`else
    assign weights = DEFAULT_WEIGHTS;
`endif

    assign pixels        = pix_q;
    assign load_done     = (fsm_q == DONE);
    assign dbg_fsm_state = fsm_q;

endmodule

// File: tb/tb_pixel_loader.sv
// Bench for pixel_loader: randomized byte streams and valid patterns checked
// against a stream-level model (expected vectors built from the byte list,
// expected in_ready/load_done from counting accepted bytes).
module tb_pixel_loader;
    import bnn_pkg::*;

    localparam int PB = 98;
`ifdef PIXEL_LOADER_WEIGHTS_EN
    localparam int WB = 9;
`else
    localparam int WB = 0;
`endif
    localparam int TOTAL = PB + WB;

    logic          clk;
    logic          rst_n;
    logic [2:0]    state;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [783:0]  pixels;
    logic [71:0]   weights;
    logic          load_done;
    loader_state_e dbg_fsm_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]   stream_q[$];
    logic [783:0] exp_pix;
    logic [71:0]  exp_wgt;
    logic [71:0]  exp_wgt_rst;

    pixel_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state         (state),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pixels        (pixels),
        .weights       (weights),
        .load_done     (load_done),
        .dbg_fsm_state (dbg_fsm_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        state    = 3'b000;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Stream builder plus reference model of the final vectors.
    task automatic build_stream(input int kind);
        stream_q.delete();
        for (int i = 0; i < PB; i++) begin
            if (kind == 0)      stream_q.push_back(8'(i + 1));
            else if (kind == 1) stream_q.push_back(8'hFF);
            else                stream_q.push_back(8'($urandom_range(0, 255)));
        end
        for (int j = 0; j < WB; j++) begin
            if (kind == 1) stream_q.push_back(8'hA5);
            else           stream_q.push_back(8'($urandom_range(0, 255)));
        end
        exp_pix = '0;
        for (int k = 0; k < PB; k++) exp_pix[8*k +: 8] = stream_q[k];
`ifdef PIXEL_LOADER_WEIGHTS_EN
        exp_wgt = '0;
        for (int j = 0; j < WB; j++) exp_wgt[8*j +: 8] = stream_q[PB + j];
`else
        exp_wgt = DEFAULT_WEIGHTS;
`endif
    endtask

    // Driver: vmode 0 = valid always, 1 = valid every other edge, 2 = random.
    // Optional pause (state leaves LOAD for 10 cycles) or reset once pause_at /
    // reset_at bytes have been accepted. Returns the edge count at load_done.
    task automatic run_load(input int vmode, input int pause_at, input int reset_at,
                            output int done_edge);
        int   idx;
        int   n;
        bit   paused;
        logic vld;
        logic exp_ready;
        idx       = 0;
        n         = 0;
        paused    = 1'b0;
        done_edge = -1;
        state     = STATE_LOAD;
        while (idx < TOTAL && n < 3000) begin
            if (pause_at >= 0 && !paused && idx == pause_at) begin
                paused = 1'b1;
                state  = 3'b000;
                for (int g = 0; g < 10; g++) begin
                    in_valid = 1'b1;
                    in_data  = 8'hEE;
                    #1;
                    n_cmp++;
                    if (in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL pause_in_ready: gap cycle %0d got %b expected 0", g, in_ready);
                    end
                    @(negedge clk);
                end
                state = STATE_LOAD;
            end
            if (reset_at >= 0 && idx == reset_at) begin
                rst_n    = 1'b0;
                in_valid = 1'b1;
                in_data  = 8'($urandom_range(0, 255));
                @(negedge clk);
                rst_n    = 1'b1;
                in_valid = 1'b0;
                #1;
                n_cmp++;
                if (pixels !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid_pixels: got %h expected 0", pixels);
                end
                n_cmp++;
                if (load_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_done: got %b expected 0", load_done);
                end
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_ready: got %b expected 0", in_ready);
                end
                n_cmp++;
                if (weights !== exp_wgt_rst) begin
                    n_fail++;
                    $display("FAIL reset_mid_weights: got %h expected %h", weights, exp_wgt_rst);
                end
                state = 3'b000;
                return;
            end
            exp_ready = (n >= 1);
            if (vmode == 0)      vld = 1'b1;
            else if (vmode == 1) vld = ((n + 1) % 2 == 0);
            else                 vld = 1'($urandom_range(0, 1));
            in_valid = vld;
            in_data  = (vld && exp_ready) ? stream_q[idx] : 8'($urandom_range(0, 255));
            #1;
            n_cmp++;
            if (in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL in_ready: edge %0d byte %0d got %b expected %b", n + 1, idx, in_ready, exp_ready);
            end
            @(negedge clk);
            n++;
            if (vld && exp_ready) idx++;
            n_cmp++;
            if (load_done !== (idx == TOTAL)) begin
                n_fail++;
                $display("FAIL load_done: edge %0d got %b expected %b", n, load_done, (idx == TOTAL));
            end
        end
        in_valid = 1'b0;
        if (idx == TOTAL) begin
            done_edge = n;
        end else begin
            n_fail++;
            n_cmp++;
            $display("FAIL load_timeout: got %0d bytes expected %0d", idx, TOTAL);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (pixels !== '0) begin
            n_fail++;
            $display("FAIL rst_pixels: got %h expected 0", pixels);
        end
        n_cmp++;
        if (weights !== exp_wgt_rst) begin
            n_fail++;
            $display("FAIL rst_weights: got %h expected %h", weights, exp_wgt_rst);
        end
        n_cmp++;
        if (load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_done: got %b expected 0", load_done);
        end
        n_cmp++;
        if (dbg_fsm_state !== IDLE) begin
            n_fail++;
            $display("FAIL rst_fsm: got %0d expected %0d", dbg_fsm_state, IDLE);
        end
        // Outside LOAD nothing is accepted even with valid bytes offered.
        for (int i = 0; i < 5; i++) begin
            state    = (i % 2 == 0) ? 3'b000 : STATE_L1;
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(1, 255));
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ready: got %b expected 0", in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        state    = 3'b000;
        n_cmp++;
        if (pixels !== '0) begin
            n_fail++;
            $display("FAIL idle_pixels: got %h expected 0", pixels);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        logic [7:0] b;
        build_stream(0);
        do_reset();
        run_load(0, -1, -1, d);
        n_cmp++;
        if (d !== 1 + TOTAL) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d edges expected %0d", d, 1 + TOTAL);
        end
        b = pixels[7:0];
        n_cmp++;
        if (b !== 8'h01) begin
            n_fail++;
            $display("FAIL b2b_first_byte: got %h expected 01", b);
        end
        b = pixels[783:776];
        n_cmp++;
        if (b !== 8'h62) begin
            n_fail++;
            $display("FAIL b2b_last_byte: got %h expected 62", b);
        end
        n_cmp++;
        if (pixels !== exp_pix) begin
            n_fail++;
            $display("FAIL b2b_pixels: got %h expected %h", pixels, exp_pix);
        end
        n_cmp++;
        if (weights !== exp_wgt) begin
            n_fail++;
            $display("FAIL b2b_weights: got %h expected %h", weights, exp_wgt);
        end
        n_cmp++;
        if (dbg_fsm_state !== DONE) begin
            n_fail++;
            $display("FAIL b2b_fsm: got %0d expected %0d", dbg_fsm_state, DONE);
        end
    endtask

    task automatic test_ones_pattern();
        int d;
        build_stream(1);
        do_reset();
        run_load(0, -1, -1, d);
        n_cmp++;
        if (d !== 1 + TOTAL) begin
            n_fail++;
            $display("FAIL ones_latency: got %0d edges expected %0d", d, 1 + TOTAL);
        end
        n_cmp++;
        if (pixels !== {784{1'b1}}) begin
            n_fail++;
            $display("FAIL ones_pixels: got %h expected all ones", pixels);
        end
        n_cmp++;
        if (weights !== exp_wgt) begin
            n_fail++;
            $display("FAIL ones_weights: got %h expected %h", weights, exp_wgt);
        end
    endtask

    task automatic test_toggle_valid();
        int d;
        build_stream(0);
        do_reset();
        run_load(1, -1, -1, d);
        n_cmp++;
        if (d !== 2 * TOTAL) begin
            n_fail++;
            $display("FAIL toggle_latency: got %0d edges expected %0d", d, 2 * TOTAL);
        end
        n_cmp++;
        if (pixels !== exp_pix) begin
            n_fail++;
            $display("FAIL toggle_pixels: got %h expected %h", pixels, exp_pix);
        end
        n_cmp++;
        if (weights !== exp_wgt) begin
            n_fail++;
            $display("FAIL toggle_weights: got %h expected %h", weights, exp_wgt);
        end
    endtask

    task automatic test_pause();
        int d;
        logic [7:0] b;
        build_stream(2);
        stream_q[41] = 8'h3C;
        exp_pix[335:328] = 8'h3C;
        do_reset();
        run_load(0, 41, -1, d);
        b = pixels[335:328];
        n_cmp++;
        if (b !== 8'h3C) begin
            n_fail++;
            $display("FAIL pause_byte41: got %h expected 3c", b);
        end
        n_cmp++;
        if (pixels !== exp_pix) begin
            n_fail++;
            $display("FAIL pause_pixels: got %h expected %h", pixels, exp_pix);
        end
        n_cmp++;
        if (weights !== exp_wgt) begin
            n_fail++;
            $display("FAIL pause_weights: got %h expected %h", weights, exp_wgt);
        end
    endtask

    task automatic test_reset_mid_load();
        int d;
        build_stream(2);
        do_reset();
        run_load(0, -1, 51, d);
        build_stream(2);
        run_load(2, -1, -1, d);
        n_cmp++;
        if (pixels !== exp_pix) begin
            n_fail++;
            $display("FAIL reload_pixels: got %h expected %h", pixels, exp_pix);
        end
        n_cmp++;
        if (weights !== exp_wgt) begin
            n_fail++;
            $display("FAIL reload_weights: got %h expected %h", weights, exp_wgt);
        end
    endtask

    task automatic test_after_done();
        int d;
        build_stream(2);
        do_reset();
        run_load(2, -1, -1, d);
        for (int i = 0; i < 20; i++) begin
            state    = (i < 10) ? STATE_LOAD : STATE_L1;
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(0, 255));
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL done_ready: extra byte %0d got %b expected 0", i, in_ready);
            end
            @(negedge clk);
            n_cmp++;
            if (load_done !== 1'b1) begin
                n_fail++;
                $display("FAIL done_sticky: extra byte %0d got %b expected 1", i, load_done);
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (pixels !== exp_pix) begin
            n_fail++;
            $display("FAIL done_pixels: got %h expected %h", pixels, exp_pix);
        end
        n_cmp++;
        if (weights !== exp_wgt) begin
            n_fail++;
            $display("FAIL done_weights: got %h expected %h", weights, exp_wgt);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        state    = 3'b000;
        in_valid = 1'b0;
        in_data  = 8'h00;
`ifdef PIXEL_LOADER_WEIGHTS_EN
        exp_wgt_rst = '0;
`else
        exp_wgt_rst = DEFAULT_WEIGHTS;
`endif
        test_reset();
        test_back_to_back();
        test_ones_pattern();
        test_toggle_valid();
        test_pause();
        test_reset_mid_load();
        test_after_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
